// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo; the master drives requests,
// the slave (the FIFO) returns read data and occupancy.
interface sync_fifo_if #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int CW = $clog2(SIZE + 1);

    logic                  ce;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         count;

    modport master (
        output ce, wr_en, wr_data, rd_en,
        input  rd_data, empty, full, count
    );

    modport slave (
        input  ce, wr_en, wr_data, rd_en,
        output rd_data, empty, full, count
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered read data, clock enable
// and synchronous active-high reset; depth need not be a power of two.
module sync_fifo #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    sync_fifo_if.slave   bus
);
    localparam int CW = $clog2(SIZE + 1);
    localparam int PW = $clog2(SIZE);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [PW-1:0]         r_wrPtr  = '0;
    logic [PW-1:0]         r_rdPtr  = '0;
    logic [CW-1:0]         r_count  = '0;
    logic [DATA_WIDTH-1:0] r_rdData = '0;

    logic w_empty;
    logic w_full;
    logic w_rdAccept;
    logic w_wrAccept;

    // Wrap explicitly at SIZE-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(SIZE - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(SIZE));
    assign w_rdAccept = bus.ce && bus.rd_en && !w_empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_wrAccept = bus.ce && bus.wr_en && (!w_full || w_rdAccept);

    always_ff @(posedge clk) begin
        if (w_wrAccept && !rst) begin
            r_mem[r_wrPtr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_rdData <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_rdAccept) begin
                r_rdData <= r_mem[r_rdPtr];
                r_rdPtr  <= nextPtr(r_rdPtr);
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rd_data = r_rdData;
    assign bus.count   = r_count;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios with literal
// expectations plus randomized traffic checked against a queue model.
module tb_sync_fifo;
    localparam int SIZE = 16;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_fifo_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

    sync_fifo #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [DW-1:0] modelQ [$];
    logic [DW-1:0] modelRd = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change only just after the falling edge, so both DUT and model see them stable.
    task automatic applyStimulus(input bit r, input bit c, input bit w, input logic [DW-1:0] d, input bit rd);
        rst         = r;
        bus.ce      = c;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference behaviour: a plain queue plus the last value popped.
    always @(posedge clk) begin
        bit rdOk;
        bit wrOk;
        if (rst) begin
            modelQ.delete();
            modelRd = '0;
        end else if (bus.ce) begin
            rdOk = bus.rd_en && (modelQ.size() != 0);
            wrOk = bus.wr_en && ((modelQ.size() < SIZE) || rdOk);
            if (rdOk) modelRd = modelQ.pop_front();
            if (wrOk) modelQ.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        checkOutput("model.rd_data", 32'(bus.rd_data), 32'(modelRd));
        checkOutput("model.count",   32'(bus.count),   32'(modelQ.size()));
        checkOutput("model.empty",   32'(bus.empty),   32'(modelQ.size() == 0));
        checkOutput("model.full",    32'(bus.full),    32'(modelQ.size() == SIZE));
    end

    initial begin
        int phase;
        bit r, c, w, rd;
        rst         = 1'b1;
        bus.ce      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        #1;
        checkOutput("powerup.count",   32'(bus.count),   32'd0);
        checkOutput("powerup.empty",   32'(bus.empty),   32'd1);
        checkOutput("powerup.rd_data", 32'(bus.rd_data), 32'd0);

        applyStimulus(1, 1, 0, 8'h00, 0);
        checkOutput("reset.count",   32'(bus.count),   32'd0);
        checkOutput("reset.empty",   32'(bus.empty),   32'd1);
        checkOutput("reset.full",    32'(bus.full),    32'd0);
        checkOutput("reset.rd_data", 32'(bus.rd_data), 32'd0);

        // Three writes then a single read
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 8'(8'hA1 + i), 0);
        checkOutput("basic.count", 32'(bus.count), 32'd3);
        checkOutput("basic.empty", 32'(bus.empty), 32'd0);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("basic.rd_data", 32'(bus.rd_data), 32'hA1);
        checkOutput("basic.count2",  32'(bus.count),   32'd2);

        // Fill, overflow attempt, drain
        applyStimulus(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < SIZE; i++) applyStimulus(0, 1, 1, 8'(i), 0);
        checkOutput("fill.full",  32'(bus.full),  32'd1);
        checkOutput("fill.count", 32'(bus.count), 32'd16);
        applyStimulus(0, 1, 1, 8'hFF, 0);
        checkOutput("overflow.count", 32'(bus.count), 32'd16);
        for (int i = 0; i < SIZE; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 1);
            checkOutput("drain.rd_data", 32'(bus.rd_data), 32'(i));
        end
        checkOutput("drain.empty", 32'(bus.empty), 32'd1);
        checkOutput("drain.count", 32'(bus.count), 32'd0);

        // Simultaneous traffic with count 5 while the write pointer wraps
        applyStimulus(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 9; i++)  applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("wrap.count0", 32'(bus.count), 32'd5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 8'(8'h30 + i), 1);
            checkOutput("wrap.rd_data", 32'(bus.rd_data), 32'(8'h19 + i));
            checkOutput("wrap.count",   32'(bus.count),   32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 1);
            checkOutput("wrap.drain", 32'(bus.rd_data), (i == 0) ? 32'h1D : 32'(8'h30 + i - 1));
        end

        // Read on empty with a same-cycle write: no bypass
        applyStimulus(1, 1, 0, 8'h00, 0);
        applyStimulus(0, 1, 1, 8'h33, 0);
        applyStimulus(0, 1, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 8'h55, 1);
        checkOutput("nobypass.rd_data", 32'(bus.rd_data), 32'h33);
        checkOutput("nobypass.count",   32'(bus.count),   32'd1);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("nobypass.next", 32'(bus.rd_data), 32'h55);

        // Write and read together while full
        applyStimulus(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < SIZE; i++) applyStimulus(0, 1, 1, 8'(8'h20 + i), 0);
        applyStimulus(0, 1, 1, 8'h77, 1);
        checkOutput("fullrw.count",   32'(bus.count),   32'd16);
        checkOutput("fullrw.rd_data", 32'(bus.rd_data), 32'h20);
        for (int i = 0; i < SIZE; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 1);
            checkOutput("fullrw.drain", 32'(bus.rd_data), (i < 15) ? 32'(8'h21 + i) : 32'h77);
        end

        // Clock enable low freezes everything; reset still works with ce low
        applyStimulus(1, 1, 0, 8'h00, 0);
        applyStimulus(0, 1, 1, 8'h42, 0);
        applyStimulus(0, 1, 1, 8'h43, 0);
        applyStimulus(0, 1, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 8'h99, 1);
            checkOutput("cehold.count",   32'(bus.count),   32'd1);
            checkOutput("cehold.rd_data", 32'(bus.rd_data), 32'h42);
        end
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("cerst.count",   32'(bus.count),   32'd0);
        checkOutput("cerst.empty",   32'(bus.empty),   32'd1);
        checkOutput("cerst.rd_data", 32'(bus.rd_data), 32'd0);

        // Randomized traffic alternating write-heavy and read-heavy phases
        for (int n = 0; n < 4000; n++) begin
            phase = (n / 150) % 3;
            r  = ($urandom_range(199) == 0);
            c  = ($urandom_range(9) != 0);
            w  = (phase == 0) ? ($urandom_range(3) != 0) : (phase == 1) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
            rd = (phase == 1) ? ($urandom_range(3) != 0) : (phase == 0) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
            applyStimulus(r, c, w, 8'($urandom), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
